agu_xlat_arbiter: RTL and testbench
===================================

AGU_XLAT_ARBITER -- requirements
Module: agu_xlat_arbiter

Interface
REQ-001 SHALL provide the following ports, one clock and a synchronous active-low reset:
- cpu_clock_i in 1: sole clock; all state updates on its rising edge.
- cpu_reset_ni in 1: synchronous active-low reset.
- flush_i in 1: pipeline flush.
- aN_virt_addr_i in 32, N=0,1: requester N virtual address.
- aN_vld_i in 1, N=0,1: requester N translation request.
- aN_is_write_i in 1, N=0,1: requester N store indicator.
- aN_ans_vld_o out 1, N=0,1: answer valid for requester N.
- translated_addr_o out 32: translated address, broadcast to both requesters.
- excp_code_o out 4: exception code, broadcast.
- excp_code_vld_o out 1: exception valid, broadcast.
- tu_virt_addr_o out 32: address to the translation unit.
- tu_vld_o out 1: request to the translation unit.
- tu_is_write_o out 1: store indicator to the translation unit.
- tu_translated_addr_i in 32: translation unit result.
- tu_excp_code_i in 4: translation unit exception code.
- tu_excp_code_vld_i in 1: translation unit exception valid.
- tu_ans_vld_i in 1: translation unit answer valid.
- conflict_cnt_o out 32: conflict counter; present only with AGU_ARB_STATS_EN.

Function
REQ-002 SHALL share one translation unit between two AGU requesters; the request path is combinational, with zero added latency.
REQ-003 SHALL implement FSM states IDLE, OWN0, OWN1, plus a 1-bit last-served register (last).
REQ-004 Selection rule:
- In OWNn, sel=n.
- In IDLE with exactly one aN_vld_i high, sel=that N.
- In IDLE with both high, sel=!last.
- In IDLE with neither high, no selection.
REQ-005 tu_virt_addr_o and tu_is_write_o SHALL mux from sel; tu_vld_o = a<sel>_vld_i & !flush_i & selection exists.
REQ-006 aN_ans_vld_o = tu_ans_vld_i & (sel==N) & tu_vld_o; the unselected requester's ans SHALL be 0.
REQ-007 translated_addr_o, excp_code_o and excp_code_vld_o SHALL pass tu_* through unconditionally; consumers qualify them with aN_ans_vld_o.
REQ-008 State transitions:
- IDLE/OWNn with a selected request and tu_ans_vld_i=1: next IDLE, last<=sel.
- IDLE with a selected request and tu_ans_vld_i=0: next OWN<sel>.
- OWNn with an_vld_i=0: next IDLE, last unchanged.
REQ-009 While in OWNn, the other requester SHALL be held off (lock) regardless of its valid, until an answer or a drop.
REQ-010 flush_i=1: tu_vld_o=0, both ans=0, next state IDLE, last unchanged; flush dominates every other transition.
REQ-011 A requester granted and answered in the same IDLE cycle SHALL NOT enter OWN; back-to-back single-cycle answers SHALL alternate under continuous dual contention.
REQ-012 No requester SHALL wait more than one complete transaction of the other (starvation-free).

Reset
REQ-013 cpu_reset_ni=0 at a clock edge SHALL set state=IDLE, last=1 (AGU0 wins the first tie), and conflict_cnt=0.
REQ-014 Reset asserted mid-transaction (OWNn) SHALL abandon the lock; the next cycle re-arbitrates from IDLE with AGU0 preferred.
REQ-015 Combinational outputs SHALL follow REQ-005/006 during reset using state IDLE; tu_vld_o may assert in reset only if a requester is valid and flush_i=0.

Configuration
REQ-016 Macro AGU_ARB_STATS_EN:
- Defined: a 32-bit conflict_cnt_o increments on every cycle where both aN_vld_i=1, flush_i=0, and one is not selected; it saturates at 32'hFFFFFFFF and clears only on reset.
- Undefined: the port and counter SHALL be absent; arbitration behaviour is identical either way.

Verification
REQ-017 Single requester: a0_vld_i=1, tu_ans_vld_i=1 same cycle -> a0_ans_vld_o=1 in that cycle, state stays IDLE, last=0.
REQ-018 Tie after reset: both valid, ans every cycle -> grants AGU0, AGU1, AGU0, AGU1 on consecutive cycles; a1_ans_vld_o=0 whenever AGU0 is granted.
REQ-019 Lock: both valid, AGU1 selected, tu_ans_vld_i=0 for 3 cycles -> state OWN1; tu_virt_addr_o = a1_virt_addr_i for all 4 cycles; AGU0 granted the cycle after AGU1's answer.
REQ-020 Flush in OWN0: flush_i=1 for 1 cycle -> tu_vld_o=0 and both ans=0 that cycle, state IDLE next, last unchanged.
REQ-021 Stats (AGU_ARB_STATS_EN): both valid for 10 cycles with no answers -> conflict_cnt_o=10; preloaded counter at 32'hFFFFFFFE plus 3 conflict cycles -> 32'hFFFFFFFF.

Source files
------------

// File: rtl/agu_xlat_arbiter_if.sv
// Request/answer bundle between two AGUs, the shared translation unit and the arbiter.
// The conflict_cnt_o signal exists only when AGU_ARB_STATS_EN is defined.
interface agu_xlat_arbiter_if;
    logic        flush_i;
    logic [31:0] a0_virt_addr_i;
    logic [31:0] a1_virt_addr_i;
    logic        a0_vld_i;
    logic        a1_vld_i;
    logic        a0_is_write_i;
    logic        a1_is_write_i;
    logic        a0_ans_vld_o;
    logic        a1_ans_vld_o;
    logic [31:0] translated_addr_o;
    logic [3:0]  excp_code_o;
    logic        excp_code_vld_o;
    logic [31:0] tu_virt_addr_o;
    logic        tu_vld_o;
    logic        tu_is_write_o;
    logic [31:0] tu_translated_addr_i;
    logic [3:0]  tu_excp_code_i;
    logic        tu_excp_code_vld_i;
    logic        tu_ans_vld_i;
`ifdef AGU_ARB_STATS_EN
    logic [31:0] conflict_cnt_o;
`endif

    modport slave (
        input  flush_i,
        input  a0_virt_addr_i, a1_virt_addr_i,
        input  a0_vld_i, a1_vld_i,
        input  a0_is_write_i, a1_is_write_i,
        output a0_ans_vld_o, a1_ans_vld_o,
        output translated_addr_o, excp_code_o, excp_code_vld_o,
        output tu_virt_addr_o, tu_vld_o, tu_is_write_o,
        input  tu_translated_addr_i, tu_excp_code_i, tu_excp_code_vld_i, tu_ans_vld_i
`ifdef AGU_ARB_STATS_EN
        ,
        output conflict_cnt_o
`endif
    );

    modport master (
        output flush_i,
        output a0_virt_addr_i, a1_virt_addr_i,
        output a0_vld_i, a1_vld_i,
        output a0_is_write_i, a1_is_write_i,
        input  a0_ans_vld_o, a1_ans_vld_o,
        input  translated_addr_o, excp_code_o, excp_code_vld_o,
        input  tu_virt_addr_o, tu_vld_o, tu_is_write_o,
        output tu_translated_addr_i, tu_excp_code_i, tu_excp_code_vld_i, tu_ans_vld_i
`ifdef AGU_ARB_STATS_EN
        ,
        input  conflict_cnt_o
`endif
    );
endinterface

// File: rtl/agu_xlat_arbiter.sv
// Two-requester arbiter in front of one address translation unit, zero-latency request path.
// Optional conflict statistics counter enabled by defining AGU_ARB_STATS_EN.
module agu_xlat_arbiter (
    input logic               cpu_clock_i,
    input logic               cpu_reset_ni,
    agu_xlat_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t state;
    state_t next_state;
    state_t cur_state;
    logic   last;
    logic   next_last;
    logic   cur_last;
    logic   has_sel;
    logic   sel;
    logic   sel_vld;
    logic   grant;

    // While reset is low the combinational path behaves as IDLE with AGU0 preferred.
    assign cur_state = cpu_reset_ni ? state : IDLE;
    assign cur_last  = cpu_reset_ni ? last  : 1'b1;

    always_comb begin
        has_sel = 1'b0;
        sel     = 1'b0;
        case (cur_state)
            OWN0: begin
                has_sel = 1'b1;
                sel     = 1'b0;
            end
            OWN1: begin
                has_sel = 1'b1;
                sel     = 1'b1;
            end
            default: begin
                if (bus.a0_vld_i && bus.a1_vld_i) begin
                    has_sel = 1'b1;
                    sel     = ~cur_last;
                end else if (bus.a0_vld_i) begin
                    has_sel = 1'b1;
                    sel     = 1'b0;
                end else if (bus.a1_vld_i) begin
                    has_sel = 1'b1;
                    sel     = 1'b1;
                end
            end
        endcase
    end

    assign sel_vld = sel ? bus.a1_vld_i : bus.a0_vld_i;
    assign grant   = has_sel & sel_vld & ~bus.flush_i;

    always_ff @(posedge cpu_clock_i) begin
        if (!cpu_reset_ni) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= next_state;
            last  <= next_last;
        end
    end

    always_comb begin
        next_state = cur_state;
        next_last  = cur_last;
        if (bus.flush_i) begin
            next_state = IDLE;
        end else if (grant && bus.tu_ans_vld_i) begin
            next_state = IDLE;
            next_last  = sel;
        end else if (grant) begin
            next_state = sel ? OWN1 : OWN0;
        end else if (cur_state != IDLE) begin
            next_state = IDLE;
        end
    end

    always_comb begin
        bus.tu_virt_addr_o    = sel ? bus.a1_virt_addr_i : bus.a0_virt_addr_i;
        bus.tu_is_write_o     = sel ? bus.a1_is_write_i : bus.a0_is_write_i;
        bus.tu_vld_o          = grant;
        bus.a0_ans_vld_o      = bus.tu_ans_vld_i & grant & ~sel;
        bus.a1_ans_vld_o      = bus.tu_ans_vld_i & grant & sel;
        bus.translated_addr_o = bus.tu_translated_addr_i;
        bus.excp_code_o       = bus.tu_excp_code_i;
        bus.excp_code_vld_o   = bus.tu_excp_code_vld_i;
    end

`ifdef AGU_ARB_STATS_EN
    logic [31:0] conflict_cnt;

    // Both requesters valid without flush always leaves one of them waiting.
    always_ff @(posedge cpu_clock_i) begin
        if (!cpu_reset_ni) begin
            conflict_cnt <= 32'd0;
        end else if (bus.a0_vld_i && bus.a1_vld_i && !bus.flush_i && conflict_cnt != 32'hFFFF_FFFF) begin
            conflict_cnt <= conflict_cnt + 32'd1;
        end
    end

    assign bus.conflict_cnt_o = conflict_cnt;
`endif

endmodule

// File: tb/tb_agu_xlat_arbiter.sv
// Directed bench for agu_xlat_arbiter: tie alternation, lock, flush, drop and reset recovery.
// Statistics checks are compiled in only when AGU_ARB_STATS_EN is defined.
module tb_agu_xlat_arbiter;

    localparam logic [31:0] ADDR0 = 32'hA000_0000;
    localparam logic [31:0] ADDR1 = 32'hB111_1110;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    agu_xlat_arbiter_if bus ();

    agu_xlat_arbiter dut (
        .cpu_clock_i  (clk),
        .cpu_reset_ni (rst_n),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle's inputs at the falling edge, settle, then let the caller check.
    task automatic cyc(input logic a0v, input logic a1v, input logic ans, input logic flush);
        @(negedge clk);
        bus.a0_vld_i     = a0v;
        bus.a1_vld_i     = a1v;
        bus.tu_ans_vld_i = ans;
        bus.flush_i      = flush;
        #1;
    endtask

    task automatic check_grant(input string tag, input logic exp_vld, input logic exp_a0,
                               input logic exp_a1, input logic [31:0] exp_addr);
        check({tag, "_tu_vld"}, {31'd0, bus.tu_vld_o}, {31'd0, exp_vld});
        check({tag, "_a0_ans"}, {31'd0, bus.a0_ans_vld_o}, {31'd0, exp_a0});
        check({tag, "_a1_ans"}, {31'd0, bus.a1_ans_vld_o}, {31'd0, exp_a1});
        check({tag, "_addr"}, bus.tu_virt_addr_o, exp_addr);
    endtask

    initial begin
        bus.a0_virt_addr_i       = ADDR0;
        bus.a1_virt_addr_i       = ADDR1;
        bus.a0_is_write_i        = 1'b0;
        bus.a1_is_write_i        = 1'b1;
        bus.a0_vld_i             = 1'b0;
        bus.a1_vld_i             = 1'b0;
        bus.flush_i              = 1'b0;
        bus.tu_ans_vld_i         = 1'b0;
        bus.tu_translated_addr_i = 32'h1234_5678;
        bus.tu_excp_code_i       = 4'h9;
        bus.tu_excp_code_vld_i   = 1'b1;

        rst_n = 1'b0;
        cyc(0, 0, 0, 0);
        check("rst_idle_tu_vld", {31'd0, bus.tu_vld_o}, 32'd0);
        check("rst_idle_a0_ans", {31'd0, bus.a0_ans_vld_o}, 32'd0);
        check("rst_idle_a1_ans", {31'd0, bus.a1_ans_vld_o}, 32'd0);
        cyc(1, 0, 0, 0);
        check("rst_req_tu_vld", {31'd0, bus.tu_vld_o}, 32'd1);
        check("rst_req_addr", bus.tu_virt_addr_o, ADDR0);
        cyc(0, 0, 0, 0);

        // Tie after reset alternates AGU0, AGU1, AGU0, AGU1.
        rst_n = 1'b1;
        cyc(1, 1, 1, 0);
        check_grant("tie1", 1, 1, 0, ADDR0);
        check("tie1_wr", {31'd0, bus.tu_is_write_o}, 32'd0);
        cyc(1, 1, 1, 0);
        check_grant("tie2", 1, 0, 1, ADDR1);
        check("tie2_wr", {31'd0, bus.tu_is_write_o}, 32'd1);
        cyc(1, 1, 1, 0);
        check_grant("tie3", 1, 1, 0, ADDR0);
        cyc(1, 1, 1, 0);
        check_grant("tie4", 1, 0, 1, ADDR1);

        cyc(1, 0, 1, 0);
        check_grant("single0", 1, 1, 0, ADDR0);
        check("pass_addr", bus.translated_addr_o, 32'h1234_5678);
        check("pass_excp", {28'd0, bus.excp_code_o}, 32'h9);
        check("pass_excp_vld", {31'd0, bus.excp_code_vld_o}, 32'd1);
        cyc(1, 1, 1, 0);
        check_grant("after_single", 1, 0, 1, ADDR1);

        // AGU1 holds the unit for three unanswered cycles, then AGU0 follows.
        cyc(1, 0, 1, 0);
        check_grant("pre_lock", 1, 1, 0, ADDR0);
        cyc(1, 1, 0, 0);
        check_grant("own1_c1", 1, 0, 0, ADDR1);
        cyc(1, 1, 0, 0);
        check_grant("own1_c2", 1, 0, 0, ADDR1);
        cyc(1, 1, 0, 0);
        check_grant("own1_c3", 1, 0, 0, ADDR1);
        cyc(1, 1, 1, 0);
        check_grant("own1_ans", 1, 0, 1, ADDR1);
        cyc(1, 1, 1, 0);
        check_grant("post_lock", 1, 1, 0, ADDR0);

        // Enter OWN0 with last=0, so only the lock keeps AGU0 selected.
        cyc(1, 0, 0, 0);
        check_grant("own0_enter", 1, 0, 0, ADDR0);
        cyc(1, 1, 0, 0);
        check_grant("own0_lock", 1, 0, 0, ADDR0);
        cyc(1, 1, 1, 1);
        check_grant("flush", 0, 0, 0, ADDR0);
        cyc(1, 1, 0, 0);
        check_grant("post_flush", 1, 0, 0, ADDR1);

        // AGU1 drops while owning; AGU0 stays locked out that cycle.
        cyc(1, 0, 1, 0);
        check("drop_tu_vld", {31'd0, bus.tu_vld_o}, 32'd0);
        check("drop_a0_ans", {31'd0, bus.a0_ans_vld_o}, 32'd0);
        cyc(1, 1, 0, 0);
        check_grant("post_drop", 1, 0, 0, ADDR1);

        // Reset while in OWN1 abandons the lock.
        rst_n = 1'b0;
        cyc(0, 0, 0, 0);
        rst_n = 1'b1;
        cyc(1, 1, 1, 0);
        check_grant("post_reset", 1, 1, 0, ADDR0);

`ifdef AGU_ARB_STATS_EN
        rst_n = 1'b0;
        cyc(0, 0, 0, 0);
        rst_n = 1'b1;
        cyc(0, 0, 0, 0);
        check("cnt_reset", bus.conflict_cnt_o, 32'd0);
        for (int i = 0; i < 10; i++) cyc(1, 1, 0, 0);
        cyc(0, 0, 0, 0);
        check("cnt_ten", bus.conflict_cnt_o, 32'd10);
        force dut.conflict_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.conflict_cnt;
        for (int i = 0; i < 3; i++) cyc(1, 1, 0, 0);
        cyc(0, 0, 0, 0);
        check("cnt_sat", bus.conflict_cnt_o, 32'hFFFF_FFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
